// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: FSM states, opcodes,
// ALUOp codes and datapath mux selects (also consumed by ALU control).
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEM_ADDR = 4'd2,
    ST_MEM_RD   = 4'd3,
    ST_MEM_WB   = 4'd4,
    ST_MEM_WR   = 4'd5,
    ST_R_EXEC   = 4'd6,
    ST_R_WB     = 4'd7,
    ST_I_EXEC   = 4'd8,
    ST_I_WB     = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_JUMP     = 4'd11,
    ST_HALT     = 4'd12
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [3:0] ALUOP_NONE = 4'b0000;
  localparam logic [3:0] ALUOP_BR   = 4'b0001;
  localparam logic [3:0] ALUOP_LW   = 4'b0010;
  localparam logic [3:0] ALUOP_SW   = 4'b0011;
  localparam logic [3:0] ALUOP_ADD  = 4'b0100;
  localparam logic [3:0] ALUOP_ORI  = 4'b0101;
  localparam logic [3:0] ALUOP_ANDI = 4'b0110;
  localparam logic [3:0] ALUOP_R    = 4'b0111;
  localparam logic [3:0] ALUOP_LUI  = 4'b1000;

  localparam logic [1:0] SRC_B_REG    = 2'b00;
  localparam logic [1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_BRANCH = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_JR     = 2'b11;

  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;

  localparam logic [1:0] MEM_TO_REG_ALU = 2'b00;
  localparam logic [1:0] MEM_TO_REG_MEM = 2'b01;
  localparam logic [1:0] MEM_TO_REG_PC  = 2'b10;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       pc_write;
    logic       pc_write_beq;
    logic       pc_write_bne;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational opcode lookup: dispatch state out of DECODE, load/store
// branch out of MEM_ADDR, per-opcode ALUOp and instruction-class flags.
module multicycle_control_decode
  import mips_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic [5:0] opcode,
  output state_e     dispatch_state,
  output state_e     mem_state,
  output logic [3:0] exec_alu_op,
  output logic       legal,
  output logic       is_beq,
  output logic       is_bne,
  output logic       is_jal
);

  always_comb begin
    dispatch_state = ILLEGAL_HALT ? ST_HALT : ST_FETCH;
    exec_alu_op    = ALUOP_NONE;
    legal          = 1'b1;
    case (opcode)
      OP_LW: begin
        dispatch_state = ST_MEM_ADDR;
        exec_alu_op    = ALUOP_LW;
      end
      OP_SW: begin
        dispatch_state = ST_MEM_ADDR;
        exec_alu_op    = ALUOP_SW;
      end
      OP_R:    dispatch_state = ST_R_EXEC;
      OP_ADDI: begin
        dispatch_state = ST_I_EXEC;
        exec_alu_op    = ALUOP_ADD;
      end
      OP_ANDI: begin
        dispatch_state = ST_I_EXEC;
        exec_alu_op    = ALUOP_ANDI;
      end
      OP_ORI: begin
        dispatch_state = ST_I_EXEC;
        exec_alu_op    = ALUOP_ORI;
      end
      OP_LUI: begin
        dispatch_state = ST_I_EXEC;
        exec_alu_op    = ALUOP_LUI;
      end
      OP_BEQ, OP_BNE: dispatch_state = ST_BRANCH;
      OP_J, OP_JAL:   dispatch_state = ST_JUMP;
      default:        legal = 1'b0;
    endcase
  end

  // Only LW and SW ever reach MEM_ADDR, so anything not LW is a store.
  assign mem_state = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
  assign is_beq    = (opcode == OP_BEQ);
  assign is_bne    = (opcode == OP_BNE);
  assign is_jal    = (opcode == OP_JAL);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main controller: Moore FSM with mem_ready/jr-qualified
// strobes, sticky illegal-opcode flag and per-instruction done pulse.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       jr,
  input  logic       mem_ready,
  output logic [3:0] alu_op,
  output logic       pc_write,
  output logic       pc_write_beq,
  output logic       pc_write_bne,
  output logic       ior_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       instr_done,
  output logic       illegal
);

  state_e     state_q, state_d;
  logic       illegal_q, illegal_d;
  state_e     dispatch_state, mem_state;
  logic [3:0] exec_alu_op;
  logic       legal, is_beq, is_bne, is_jal;
  ctrl_t      ctrl;

  multicycle_control_decode #(
    .ILLEGAL_HALT(ILLEGAL_HALT)
  ) u_decode (
    .opcode        (opcode),
    .dispatch_state(dispatch_state),
    .mem_state     (mem_state),
    .exec_alu_op   (exec_alu_op),
    .legal         (legal),
    .is_beq        (is_beq),
    .is_bne        (is_bne),
    .is_jal        (is_jal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_FETCH:    if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        state_d = dispatch_state;
        if (!legal) illegal_d = 1'b1;
      end
      ST_MEM_ADDR: state_d = mem_state;
      ST_MEM_RD:   if (mem_ready) state_d = ST_MEM_WB;
      ST_MEM_WB:   state_d = ST_FETCH;
      ST_MEM_WR:   if (mem_ready) state_d = ST_FETCH;
      ST_R_EXEC:   state_d = jr ? ST_FETCH : ST_R_WB;
      ST_R_WB:     state_d = ST_FETCH;
      ST_I_EXEC:   state_d = ST_I_WB;
      ST_I_WB:     state_d = ST_FETCH;
      ST_BRANCH:   state_d = ST_FETCH;
      ST_JUMP:     state_d = ST_FETCH;
      ST_HALT:     state_d = ST_HALT;
      default:     state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      ST_FETCH: begin
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRC_B_FOUR;
        if (mem_ready) begin
          ctrl.ir_write  = 1'b1;
          ctrl.pc_write  = 1'b1;
          ctrl.pc_source = PC_SRC_ALU;
        end
      end
      ST_DECODE: begin
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.alu_src_b = SRC_B_BRANCH;
      end
      ST_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = exec_alu_op;
      end
      ST_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.ior_d    = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REG_DST_RT;
        ctrl.mem_to_reg = MEM_TO_REG_MEM;
        ctrl.instr_done = 1'b1;
      end
      ST_MEM_WR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.ior_d      = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      ST_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_REG;
        ctrl.alu_op    = ALUOP_R;
        if (jr) begin
          ctrl.pc_write   = 1'b1;
          ctrl.pc_source  = PC_SRC_JR;
          ctrl.instr_done = 1'b1;
        end
      end
      ST_R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REG_DST_RD;
        ctrl.mem_to_reg = MEM_TO_REG_ALU;
        ctrl.instr_done = 1'b1;
      end
      ST_I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = exec_alu_op;
      end
      ST_I_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REG_DST_RT;
        ctrl.mem_to_reg = MEM_TO_REG_ALU;
        ctrl.instr_done = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a    = 1'b1;
        ctrl.alu_src_b    = SRC_B_REG;
        ctrl.alu_op       = ALUOP_BR;
        ctrl.pc_source    = PC_SRC_ALUOUT;
        ctrl.pc_write_beq = is_beq;
        ctrl.pc_write_bne = is_bne;
        ctrl.instr_done   = 1'b1;
      end
      ST_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PC_SRC_JUMP;
        ctrl.instr_done = 1'b1;
        if (is_jal) begin
          ctrl.reg_write  = 1'b1;
          ctrl.reg_dst    = REG_DST_RA;
          ctrl.mem_to_reg = MEM_TO_REG_PC;
        end
      end
      default: ;
    endcase
    // A reset cycle must never commit architectural state.
    if (reset) begin
      ctrl.pc_write     = 1'b0;
      ctrl.pc_write_beq = 1'b0;
      ctrl.pc_write_bne = 1'b0;
      ctrl.mem_write    = 1'b0;
      ctrl.ir_write     = 1'b0;
      ctrl.reg_write    = 1'b0;
    end
  end

  assign alu_op       = ctrl.alu_op;
  assign pc_write     = ctrl.pc_write;
  assign pc_write_beq = ctrl.pc_write_beq;
  assign pc_write_bne = ctrl.pc_write_bne;
  assign ior_d        = ctrl.ior_d;
  assign mem_read     = ctrl.mem_read;
  assign mem_write    = ctrl.mem_write;
  assign ir_write     = ctrl.ir_write;
  assign reg_write    = ctrl.reg_write;
  assign alu_src_a    = ctrl.alu_src_a;
  assign alu_src_b    = ctrl.alu_src_b;
  assign pc_source    = ctrl.pc_source;
  assign reg_dst      = ctrl.reg_dst;
  assign mem_to_reg   = ctrl.mem_to_reg;
  assign instr_done   = ctrl.instr_done;
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction cycle plans built from the
// instruction rules, a directed table, corner sequences and random mixes.
module tb_multicycle_control;

  localparam logic [5:0] T_R = 6'b000000, T_J = 6'b000010, T_JAL = 6'b000011;
  localparam logic [5:0] T_BEQ = 6'b000100, T_BNE = 6'b000101, T_ADDI = 6'b001000;
  localparam logic [5:0] T_ANDI = 6'b001100, T_ORI = 6'b001101, T_LUI = 6'b001111;
  localparam logic [5:0] T_LW = 6'b100011, T_SW = 6'b101011, T_BAD = 6'b111111;

  logic clk = 1'b0, reset = 1'b1, jr = 1'b0, mem_ready = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic [3:0] alu_op;
  logic pc_write, pc_write_beq, pc_write_bne, ior_d, mem_read, mem_write;
  logic ir_write, reg_write, alu_src_a, instr_done, illegal;
  logic [1:0] alu_src_b, pc_source, reg_dst, mem_to_reg;

  multicycle_control #(.ILLEGAL_HALT(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .jr(jr), .mem_ready(mem_ready),
    .alu_op(alu_op), .pc_write(pc_write), .pc_write_beq(pc_write_beq),
    .pc_write_bne(pc_write_bne), .ior_d(ior_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .instr_done(instr_done),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] alu_op;
    logic pc_write, pc_write_beq, pc_write_bne, ior_d, mem_read, mem_write;
    logic ir_write, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_source, reg_dst, mem_to_reg;
    logic instr_done, illegal;
  } outs_t;

  typedef struct {
    logic  mr;
    outs_t exp;
    int    phase;
  } cyc_t;

  typedef struct {
    logic [5:0] op;
    logic       jr_v;
    int         fw;
    int         mw;
    int         exp_cycles;
  } vec_t;

  outs_t got_w;
  assign got_w = {alu_op, pc_write, pc_write_beq, pc_write_bne, ior_d, mem_read,
                  mem_write, ir_write, reg_write, alu_src_a, alu_src_b, pc_source,
                  reg_dst, mem_to_reg, instr_done, illegal};

  cyc_t plan[$];
  int   tests = 0;
  int   fails = 0;
  logic model_illegal = 1'b0;

  function automatic string phase_name(input int p);
    case (p)
      0: return "fetch_wait";  1: return "fetch";     2: return "decode";
      3: return "mem_addr";    4: return "mem_wait";  5: return "mem_done";
      6: return "writeback";   7: return "exec";      8: return "branch";
      9: return "jump";        10: return "halt";
      default: return "other";
    endcase
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic add(input logic mr, input outs_t o, input int ph);
    cyc_t c;
    o.illegal = model_illegal;
    c.mr = mr; c.exp = o; c.phase = ph;
    plan.push_back(c);
  endtask

  task automatic check(input outs_t got, input outs_t exp, input string name, input int idx);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s[%0d] got=%06h expected=%06h op=%06b", name, idx, got, exp, opcode);
    end
  endtask

  // Expected per-cycle behaviour of one instruction, starting in instruction fetch.
  task automatic plan_instr(input logic [5:0] op, input logic jr_v, input int fw, input int mw);
    outs_t o;
    plan.delete();
    o = '0; o.alu_op = 4'b0100; o.mem_read = 1'b1; o.alu_src_b = 2'b01;
    for (int w = 0; w < fw; w++) add(1'b0, o, 0);
    o.ir_write = 1'b1; o.pc_write = 1'b1;
    add(1'b1, o, 1);
    o = '0; o.alu_op = 4'b0100; o.alu_src_b = 2'b11;
    add(rbit(), o, 2);
    case (op)
      T_LW, T_SW: begin
        o = '0; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
        o.alu_op = (op == T_LW) ? 4'b0010 : 4'b0011;
        add(rbit(), o, 3);
        o = '0; o.ior_d = 1'b1;
        if (op == T_LW) o.mem_read = 1'b1; else o.mem_write = 1'b1;
        for (int w = 0; w < mw; w++) add(1'b0, o, 4);
        if (op == T_SW) o.instr_done = 1'b1;
        add(1'b1, o, 5);
        if (op == T_LW) begin
          o = '0; o.reg_write = 1'b1; o.mem_to_reg = 2'b01; o.instr_done = 1'b1;
          add(rbit(), o, 6);
        end
      end
      T_R: begin
        o = '0; o.alu_src_a = 1'b1; o.alu_op = 4'b0111;
        if (jr_v) begin
          o.pc_write = 1'b1; o.pc_source = 2'b11; o.instr_done = 1'b1;
          add(rbit(), o, 7);
        end else begin
          add(rbit(), o, 7);
          o = '0; o.reg_write = 1'b1; o.reg_dst = 2'b01; o.instr_done = 1'b1;
          add(rbit(), o, 6);
        end
      end
      T_ADDI, T_ANDI, T_ORI, T_LUI: begin
        o = '0; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
        o.alu_op = (op == T_ADDI) ? 4'b0100 : (op == T_ORI) ? 4'b0101 :
                   (op == T_ANDI) ? 4'b0110 : 4'b1000;
        add(rbit(), o, 7);
        o = '0; o.reg_write = 1'b1; o.instr_done = 1'b1;
        add(rbit(), o, 6);
      end
      T_BEQ, T_BNE: begin
        o = '0; o.alu_src_a = 1'b1; o.alu_op = 4'b0001; o.pc_source = 2'b01;
        o.pc_write_beq = (op == T_BEQ); o.pc_write_bne = (op == T_BNE);
        o.instr_done = 1'b1;
        add(rbit(), o, 8);
      end
      T_J, T_JAL: begin
        o = '0; o.pc_write = 1'b1; o.pc_source = 2'b10; o.instr_done = 1'b1;
        if (op == T_JAL) begin
          o.reg_write = 1'b1; o.reg_dst = 2'b10; o.mem_to_reg = 2'b10;
        end
        add(rbit(), o, 9);
      end
      default: begin
        model_illegal = 1'b1;
        o = '0;
        for (int h = 0; h < 10; h++) add(rbit(), o, 10);
      end
    endcase
  endtask

  // Entered shortly after a rising edge; leaves 1 ns after a rising edge.
  task automatic run_plan(input int limit, output int done_cyc);
    done_cyc = 0;
    for (int i = 0; i < plan.size() && i < limit; i++) begin
      mem_ready = plan[i].mr;
      jr = (opcode == T_R) ? jr : rbit();
      #2;
      check(got_w, plan[i].exp, phase_name(plan[i].phase), i);
      if (got_w.instr_done === 1'b1 && done_cyc == 0) done_cyc = i + 1;
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    outs_t o;
    model_illegal = 1'b0;
    reset = 1'b1; mem_ready = 1'b1;
    @(posedge clk); #1;
    #1;
    o = '0; o.alu_op = 4'b0100; o.mem_read = 1'b1; o.alu_src_b = 2'b01;
    check(got_w, o, "reset_cycle", 0);
    reset = 1'b0;
  endtask

  task automatic check_int(input int got, input int exp, input string name);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  vec_t vecs[12];
  logic [5:0] legal_ops[11];

  initial begin
    int d;
    outs_t o;
    vecs[0]  = '{T_ADDI, 1'b0, 0, 0, 4};
    vecs[1]  = '{T_LW,   1'b0, 0, 3, 8};
    vecs[2]  = '{T_R,    1'b1, 0, 0, 3};
    vecs[3]  = '{T_R,    1'b0, 0, 0, 4};
    vecs[4]  = '{T_BNE,  1'b0, 0, 0, 3};
    vecs[5]  = '{T_BEQ,  1'b0, 1, 0, 4};
    vecs[6]  = '{T_JAL,  1'b0, 0, 0, 3};
    vecs[7]  = '{T_J,    1'b1, 0, 0, 3};
    vecs[8]  = '{T_SW,   1'b0, 0, 2, 6};
    vecs[9]  = '{T_LUI,  1'b0, 0, 0, 4};
    vecs[10] = '{T_ORI,  1'b1, 2, 0, 6};
    vecs[11] = '{T_ANDI, 1'b0, 0, 0, 4};
    legal_ops = '{T_R, T_J, T_JAL, T_BEQ, T_BNE, T_ADDI, T_ANDI, T_ORI, T_LUI, T_LW, T_SW};

    do_reset();

    foreach (vecs[k]) begin
      opcode = vecs[k].op; jr = vecs[k].jr_v;
      plan_instr(vecs[k].op, vecs[k].jr_v, vecs[k].fw, vecs[k].mw);
      run_plan(1000, d);
      check_int(d, vecs[k].exp_cycles, $sformatf("done_cycle_vec%0d", k));
    end

    // Reset while a store is still waiting on memory.
    opcode = T_SW; jr = 1'b0;
    plan_instr(T_SW, 1'b0, 0, 5);
    run_plan(5, d);
    reset = 1'b1; mem_ready = 1'b0;
    #1;
    o = '0; o.ior_d = 1'b1;
    check(got_w, o, "reset_in_mem_wr", 0);
    @(posedge clk); #1;
    reset = 1'b0; mem_ready = 1'b0;
    #1;
    o = '0; o.alu_op = 4'b0100; o.mem_read = 1'b1; o.alu_src_b = 2'b01;
    check(got_w, o, "fetch_after_reset", 0);
    @(posedge clk); #1;

    for (int n = 0; n < 150; n++) begin
      opcode = legal_ops[$urandom_range(0, 10)];
      jr = rbit();
      plan_instr(opcode, jr, $urandom_range(0, 2), $urandom_range(0, 3));
      run_plan(1000, d);
      check_int(d, plan.size(), $sformatf("rand_done_cycle%0d", n));
    end

    // Unknown opcode parks the controller until reset.
    opcode = T_BAD; jr = 1'b0;
    plan_instr(T_BAD, 1'b0, 1, 0);
    run_plan(1000, d);
    check_int(d, 0, "illegal_no_done");
    do_reset();
    opcode = T_ADDI; jr = 1'b0;
    plan_instr(T_ADDI, 1'b0, 0, 0);
    run_plan(1000, d);
    check_int(d, 4, "addi_after_halt");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
